// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - packet type, timestamp width and injector FSM states
package packet_pkg;

  localparam int TS_W = 32;

  typedef struct packed {
    logic [3:0]      src;
    logic [3:0]      dst;
    logic [15:0]     payload;
    logic [TS_W-1:0] timestamp;
  } packet_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } inj_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with first-word-fall-through head
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful behind valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wg_injector.sv
// rtl/wg_injector.sv - rate-limited, credit-gated packet launcher into the waveguide
module wg_injector
  import packet_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  packet_t                           in_pkt,
  input  logic                              in_valid,
  output logic                              in_ready,
  output packet_t                           wg_data,
  output logic                              wg_valid,
  input  logic                              done_in,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              credit_err
);

  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [FCNT_W-1:0] FIFO_CAP = FCNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);

  inj_state_t        state;
  inj_state_t        state_next;
  logic [GAP_W-1:0]  gap_cnt;
  logic [GAP_W-1:0]  gap_next;
  logic [TS_W-1:0]   cycle_cnt;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              launch;
  logic              credit_ret;
  packet_t           head;

  // Readiness comes from occupancy alone, so a same-cycle pop never opens a full FIFO.
  assign in_ready   = (fifo_count < FIFO_CAP);
  assign push       = in_valid && in_ready && !fifo_full;
  assign credit_ret = done_in && (inflight != '0);

  sync_fifo #(
    .T     (packet_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_pkt),
    .pop       (launch),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state and gap counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  // Launch decision and IDLE/GAP sequencing.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && (inflight < MAX_CNT)) begin
          launch = 1'b1;
          if (GAP_CYCLES != 0) begin
            state_next = GAP;
            gap_next   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_next = IDLE;
        else                      gap_next   = gap_cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Free-running launch-time reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 1'b1;
  end

  // Waveguide drive; the stamp is the counter value seen while wg_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wg_valid <= 1'b0;
      wg_data  <= '0;
    end else begin
      wg_valid <= launch;
      if (launch) begin
        wg_data           <= head;
        wg_data.timestamp <= cycle_cnt + 1'b1;
      end
    end
  end

  // In-flight credits; a stray return is dropped and latched as an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight   <= '0;
      credit_err <= 1'b0;
    end else begin
      if (done_in && (inflight == '0)) credit_err <= 1'b1;
      if (launch && !credit_ret)      inflight <= inflight + 1'b1;
      else if (!launch && credit_ret) inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_wg_injector.sv
// tb/tb_wg_injector.sv - self-checking bench for wg_injector over three parameter sets
module tb_wg_injector;
  import packet_pkg::*;

  localparam int N = 3;
  localparam int DEP  [N] = '{4, 4, 4};
  localparam int MAXI [N] = '{2, 4, 4};
  localparam int GAPC [N] = '{1, 2, 0};

  logic    clk = 1'b0;
  logic    rst;
  packet_t in_pkt;
  logic    in_valid;
  logic    done_in;
  logic    in_ready   [N];
  packet_t wg_data    [N];
  logic    wg_valid   [N];
  logic    credit_err [N];
  logic [1:0] infl_a;
  logic [2:0] infl_b;
  logic [2:0] infl_c;
  int      dut_infl [N];

  always #5 clk = ~clk;

  always_comb begin
    dut_infl[0] = int'(infl_a);
    dut_infl[1] = int'(infl_b);
    dut_infl[2] = int'(infl_c);
  end

  wg_injector #(.FIFO_DEPTH(4), .MAX_INFLIGHT(2), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready[0]),
    .wg_data(wg_data[0]), .wg_valid(wg_valid[0]), .done_in(done_in),
    .inflight(infl_a), .credit_err(credit_err[0]));

  wg_injector #(.FIFO_DEPTH(4), .MAX_INFLIGHT(4), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready[1]),
    .wg_data(wg_data[1]), .wg_valid(wg_valid[1]), .done_in(done_in),
    .inflight(infl_b), .credit_err(credit_err[1]));

  wg_injector #(.FIFO_DEPTH(4), .MAX_INFLIGHT(4), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready[2]),
    .wg_data(wg_data[2]), .wg_valid(wg_valid[2]), .done_in(done_in),
    .inflight(infl_c), .credit_err(credit_err[2]));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic packet_t mk(input int k);
    packet_t p;
    p.src       = 4'(k);
    p.dst       = 4'(15 - k);
    p.payload   = 16'hA000 + 16'(k);
    p.timestamp = 32'hDEAD_0000 + 32'(k);
    return p;
  endfunction

  // Behavioural model: a packet queue, a credit count and a cooldown per instance.
  packet_t mq [N][$];
  int      m_infl [N];
  int      m_cool [N];
  bit      m_err  [N];
  bit      m_valid[N];
  packet_t m_data [N];
  int      m_cyc;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_infl[i]  = 0;
      m_cool[i]  = 0;
      m_err[i]   = 1'b0;
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_cyc = 0;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      bit rdy;
      bit go;
      rdy = (mq[i].size() < DEP[i]);
      go  = (mq[i].size() > 0) && (m_infl[i] < MAXI[i]) && (m_cool[i] == 0);
      m_valid[i] = go;
      if (go) begin
        m_data[i]           = mq[i].pop_front();
        m_data[i].timestamp = 32'(m_cyc + 1);
        m_cool[i]           = GAPC[i];
      end else if (m_cool[i] > 0) begin
        m_cool[i]--;
      end
      if (done_in && m_infl[i] == 0) begin
        m_err[i]  = 1'b1;
        m_infl[i] = m_infl[i] + int'(go);
      end else begin
        m_infl[i] = m_infl[i] + int'(go) - int'(done_in);
      end
      if (in_valid && rdy) mq[i].push_back(in_pkt);
    end
    m_cyc++;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison against the model, plus a log of observed launches.
  int lc [N][$];
  int lp [N][$];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("in_ready[%0d]@%0d", i, m_cyc),   in_ready[i],   m_bit(mq[i].size() < DEP[i]));
        chk($sformatf("wg_valid[%0d]@%0d", i, m_cyc),   wg_valid[i],   m_valid[i]);
        chk($sformatf("wg_data[%0d]@%0d", i, m_cyc),    wg_data[i],    m_data[i]);
        chk($sformatf("inflight[%0d]@%0d", i, m_cyc),   dut_infl[i],   m_infl[i]);
        chk($sformatf("credit_err[%0d]@%0d", i, m_cyc), credit_err[i], m_err[i]);
        if (wg_valid[i] === 1'b1) begin
          lc[i].push_back(m_cyc);
          lp[i].push_back(int'(wg_data[i].payload - 16'hA000));
        end
      end
    end
  end

  function automatic logic m_bit(input bit b);
    return b;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < N; i++) begin
      lc[i].delete();
      lp[i].delete();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    done_in  = 1'b0;
    in_pkt   = '0;
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic chk_seq(input string nm, input int i, input int n, input int cyc [8], input int pay [8]);
    chk({nm, " count"}, lc[i].size(), n);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s cycle%0d", nm, j), (j < lc[i].size()) ? lc[i][j] : -1, cyc[j]);
      chk($sformatf("%s pkt%0d", nm, j),   (j < lp[i].size()) ? lp[i][j] : -1, pay[j]);
    end
  endtask

  initial begin
    bit b_ready_ok;
    do_reset();
    chk("reset in_ready",   in_ready[0],   1);
    chk("reset wg_valid",   wg_valid[0],   0);
    chk("reset wg_data",    wg_data[0],    0);
    chk("reset inflight",   dut_infl[0],   0);
    chk("reset credit_err", credit_err[0], 0);

    // single packet pushed on cycle 5
    repeat (4) tick();
    in_pkt = mk(0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1 no bypass", wg_valid[0], 0);
    tick();
    chk("t1 pulse",    wg_valid[0], 1);
    chk("t1 stamp",    wg_data[0].timestamp, 6);
    chk("t1 payload",  wg_data[0].payload, 16'hA000);
    chk("t1 inflight", dut_infl[0], 1);
    tick();
    chk("t1 one cycle", wg_valid[0], 0);
    chk("t1 hold",      wg_data[0].timestamp, 6);
    repeat (2) tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("t1 credit back", dut_infl[0], 0);
    chk("t1 no err",      credit_err[0], 0);

    // four back-to-back pushes across all gap settings
    do_reset();
    b_ready_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_pkt = mk(k); in_valid = 1'b1;
      if (in_ready[1] !== 1'b1) b_ready_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    chk("t2 gap2 in_ready held", b_ready_ok, 1);
    chk_seq("t2 gap2", 1, 4, '{2, 5, 8, 11, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0});
    chk_seq("t2 gap0", 2, 4, '{2, 3, 4, 5, 0, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0});
    chk("t3 stalled inflight", dut_infl[0], 2);
    chk("t3 stalled in_ready", in_ready[0], 1);

    // one credit releases one launch on the following edge
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("t3 credit inflight", dut_infl[0], 1);
    chk("t3 not same edge",   wg_valid[0], 0);
    tick();
    chk("t3 release pulse",    wg_valid[0], 1);
    chk("t3 release inflight", dut_infl[0], 2);
    repeat (4) tick();

    // fill the FIFO with credits exhausted
    for (int k = 4; k < 7; k++) begin
      in_pkt = mk(k); in_valid = 1'b1;
      tick();
    end
    chk("t4 full ready", in_ready[0], 0);
    in_pkt = mk(7);
    repeat (2) tick();
    chk("t4 5th refused", in_ready[0], 0);
    in_valid = 1'b0;
    tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("t4 still full", in_ready[0], 0);
    tick();
    chk("t4 pop pulse",  wg_valid[0], 1);
    chk("t4 ready back", in_ready[0], 1);
    for (int r = 0; r < 3; r++) begin
      tick();
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
    end
    repeat (5) tick();
    chk_seq("t4 lim2", 0, 7, '{2, 4, 16, 28, 31, 33, 35, 0}, '{0, 1, 2, 3, 4, 5, 6, 0});

    // coincident launch and credit, then a stray credit
    do_reset();
    in_pkt = mk(8); in_valid = 1'b1;
    tick();
    in_pkt = mk(9);
    tick();
    in_valid = 1'b0;
    tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("t5 coincident pulse",    wg_valid[0], 1);
    chk("t5 coincident inflight", dut_infl[0], 1);
    tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("t5 drained", dut_infl[0], 0);
    chk("t5 no err",  credit_err[0], 0);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("t5 stray err",      credit_err[0], 1);
    chk("t5 stray saturate", dut_infl[0], 0);
    repeat (3) tick();
    chk("t5 err sticky", credit_err[0], 1);

    // reset while packets are queued and one is on the waveguide
    do_reset();
    chk("t6 err cleared", credit_err[0], 0);
    for (int k = 10; k < 15; k++) begin
      in_pkt = mk(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("t6 pulse before rst", wg_valid[1], 1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t6 rst wg_valid%0d", i), wg_valid[i],   0);
      chk($sformatf("t6 rst wg_data%0d", i),  wg_data[i],    0);
      chk($sformatf("t6 rst inflight%0d", i), dut_infl[i],   0);
      chk($sformatf("t6 rst in_ready%0d", i), in_ready[i],   1);
      chk($sformatf("t6 rst err%0d", i),      credit_err[i], 0);
    end
    tick();
    rst = 1'b0;
    clear_log();
    repeat (10) tick();
    for (int i = 0; i < N; i++)
      chk($sformatf("t6 silent%0d", i), lc[i].size(), 0);
    in_pkt = mk(15); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6 restart pulse", wg_valid[1], 1);
    chk("t6 restart stamp", wg_data[1].timestamp, 12);
    chk("t6 restart pkt",   wg_data[1].payload, 16'hA00F);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
